// File: rtl/seq_counter_arbiter.sv
// seq_counter_arbiter
//   Round-robin arbiter that shares one step-enabled sequence counter between
//   N_REQ requesters. For each granted run it restarts the counter, issues
//   the requested number of step enables, then hands back the final code.
//
// Ports
//   clk      rising-edge clock
//   clear    asynchronous active-low reset
//   req      per-requester run request (level, held until done/abandoned)
//   len      per-requester step count, slice i = len[i*LEN_W +: LEN_W];
//            0 means 2^LEN_W steps
//   seq_q    current code from the sequence counter
//   seq_clr  one-cycle restart pulse to the counter
//   step_en  counter advances on each edge where high
//   grant    one-hot owner of the counter, 0 when idle
//   busy     high in every state except IDLE
//   done     one-cycle completion pulse to the owner
//   result   counter code captured at completion, held until the next one
//   abort    one-cycle pulse when the owner drops req mid-run
module seq_counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] len,
    input  logic [CNT_W-1:0]       seq_q,
    output logic                   seq_clr,
    output logic                   step_en,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic [CNT_W-1:0]       result,
    output logic                   abort
);

    localparam int IW = $clog2(N_REQ);
    // A zero length field stands for a full 2^LEN_W-step run.
    localparam logic [LEN_W:0] REM_FULL = (LEN_W+1)'(1) << LEN_W;

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [N_REQ-1:0]     grant_reg, grant_next;
    logic [IW-1:0]        ptr_reg, ptr_next;
    logic [LEN_W:0]       rem_reg, rem_next;
    logic                 seq_clr_reg, seq_clr_next;
    logic                 step_en_reg, step_en_next;
    logic [N_REQ-1:0]     done_reg, done_next;
    logic [CNT_W-1:0]     result_reg, result_next;
    logic                 abort_reg, abort_next;
    logic                 busy_reg, busy_next;

    logic [LEN_W-1:0]     len_arr [N_REQ];
    logic [IW-1:0]        win;
    logic [IW-1:0]        cand;
    logic                 found;
    logic                 owner_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Round-robin search: first set req bit strictly after the pointer, wrapping.
    always_comb begin
        win   = ptr_reg;
        cand  = ptr_reg;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_reg) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // The owner still wants the counter only while its own req bit is held.
    assign owner_req = |(req & grant_reg);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= IW'(N_REQ - 1);
            rem_reg     <= '0;
            seq_clr_reg <= 1'b0;
            step_en_reg <= 1'b0;
            done_reg    <= '0;
            result_reg  <= '0;
            abort_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            ptr_reg     <= ptr_next;
            rem_reg     <= rem_next;
            seq_clr_reg <= seq_clr_next;
            step_en_reg <= step_en_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
            abort_reg   <= abort_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        ptr_next     = ptr_reg;
        rem_next     = rem_reg;
        seq_clr_next = 1'b0;
        step_en_next = 1'b0;
        done_next    = '0;
        result_next  = result_reg;
        abort_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next   = CLR;
                    grant_next   = N_REQ'(1) << win;
                    ptr_next     = win;
                    seq_clr_next = 1'b1;
                    rem_next     = (len_arr[win] == '0) ? REM_FULL
                                                        : {1'b0, len_arr[win]};
                end
            end
            CLR: begin
                if (!owner_req) begin
                    state_next = IDLE;
                    grant_next = '0;
                    abort_next = 1'b1;
                end else begin
                    state_next   = RUN;
                    step_en_next = 1'b1;
                end
            end
            RUN: begin
                // Every RUN cycle has step_en high, so each edge here is one step.
                rem_next = rem_reg - 1'b1;
                if (!owner_req) begin
                    state_next = IDLE;
                    grant_next = '0;
                    abort_next = 1'b1;
                end else if (rem_reg == (LEN_W+1)'(1)) begin
                    state_next = DONE;
                    done_next  = grant_reg;
                end else begin
                    step_en_next = 1'b1;
                end
            end
            DONE: begin
                // The last step has landed, so seq_q now holds the final code.
                result_next = seq_q;
                grant_next  = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign seq_clr = seq_clr_reg;
    assign step_en = step_en_reg;
    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign abort   = abort_reg;

endmodule

// File: tb/tb_seq_counter_arbiter.sv
// Self-checking bench for seq_counter_arbiter with a small sequence-counter
// model (code order 0000,0001,1111,0010,...) and a scoreboard of expected runs.
module tb_seq_counter_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  seq_q;
    logic        seq_clr, step_en, busy, abort;
    logic [3:0]  grant, done, result;

    typedef struct {
        int id;
        int steps;
        bit ab;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [3:0] idx = '0;

    seq_counter_arbiter #(.N_REQ(4), .CNT_W(4), .LEN_W(4)) dut (
        .clk(clk), .clear(clear), .req(req), .len(len), .seq_q(seq_q),
        .seq_clr(seq_clr), .step_en(step_en), .grant(grant), .busy(busy),
        .done(done), .result(result), .abort(abort)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] seq_code(input int i);
        case (i % 16)
            0: return 4'h0;  1: return 4'h1;  2: return 4'hF;  3: return 4'h2;
            4: return 4'hE;  5: return 4'h3;  6: return 4'hD;  7: return 4'h4;
            8: return 4'hC;  9: return 4'h5; 10: return 4'hB; 11: return 4'h6;
            12: return 4'hA; 13: return 4'h7; 14: return 4'h9; default: return 4'h8;
        endcase
    endfunction

    // Sequence counter model driven by the DUT's control outputs.
    always @(posedge clk) begin
        if (seq_clr) idx <= '0;
        else if (step_en) idx <= idx + 4'd1;
    end
    assign seq_q = seq_code(int'(idx));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: per-run step/busy accounting and scoreboard comparison.
    logic [3:0] prev_grant = '0;
    int  run_steps = 0;
    int  busy_cnt = 0;
    bit  result_pending = 0;
    logic [3:0] exp_result = '0;
    logic [3:0] last_result = '0;

    always @(negedge clk) begin
        if (!clear) begin
            prev_grant     = '0;
            result_pending = 0;
            last_result    = '0;
        end else begin
            chk("clr_step_excl", int'(seq_clr & step_en), 0);
            if (grant != 0 && prev_grant == 0) begin
                run_steps = 0;
                busy_cnt  = 0;
            end
            if (step_en) run_steps++;
            if (busy) busy_cnt++;
            if (result_pending) begin
                chk("result", int'(result), int'(exp_result));
                last_result    = exp_result;
                result_pending = 0;
            end
            if (done != 0) begin
                chk("sb_nonempty_done", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_vec", int'(done), 1 << e.id);
                    chk("done_grant", int'(grant), int'(done));
                    chk("run_steps", run_steps, e.steps);
                    chk("run_busy", busy_cnt, e.steps + 2);
                    chk("not_abort", int'(e.ab), 0);
                    chk("result_hold", int'(result), int'(last_result));
                    exp_result     = seq_code(e.steps);
                    result_pending = 1;
                    $display("run id=%0d steps=%0d busy=%0d expect_result=%h",
                             e.id, run_steps, busy_cnt, exp_result);
                end
            end
            if (abort) begin
                chk("sb_nonempty_abort", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("abort_expected", int'(e.ab), 1);
                    chk("abort_grant", int'(grant), 0);
                    chk("abort_done", int'(done), 0);
                    chk("abort_step", int'(step_en), 0);
                    chk("abort_result", int'(result), int'(last_result));
                    $display("abort id=%0d after steps=%0d", e.id, run_steps);
                end
            end
            prev_grant = grant;
        end
    end

    task automatic push(input int id, input int steps, input bit ab);
        sb_entry_t t;
        t.id = id; t.steps = steps; t.ab = ab;
        sb.push_back(t);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (done == 0 && n < budget);
        chk("wait_done", int'(done != 0), 1);
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (grant == 0 && n < budget);
        chk("wait_grant", int'(grant != 0), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   int'(grant),   0);
        chk({tag, "_busy"},    int'(busy),    0);
        chk({tag, "_done"},    int'(done),    0);
        chk({tag, "_seq_clr"}, int'(seq_clr), 0);
        chk({tag, "_step_en"}, int'(step_en), 0);
        chk({tag, "_abort"},   int'(abort),   0);
        chk({tag, "_result"},  int'(result),  0);
    endtask

    int t_prev;

    initial begin
        clear = 1'b0; req = '0; len = '0;
        idle(3);
        chk_all_zero("reset");
        clear = 1'b1;
        idle(1);

        // 1: single run of 3 steps
        len[3:0] = 4'd3; req = 4'b0001; push(0, 3, 0);
        idle(1);
        chk("t1_grant", int'(grant), 1);
        chk("t1_seq_clr", int'(seq_clr), 1);
        wait_done(20);
        req = '0;
        idle(3);

        // 2: all request, len=1, round-robin order from reset
        clear = 1'b0; idle(1); clear = 1'b1;
        len = 16'h1111;
        push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 1, 0); push(0, 1, 0);
        req = 4'b1111;
        t_prev = 0;
        for (int r = 0; r < 5; r++) begin
            wait_done(20);
            chk("t2_order", int'(done), 1 << (r % 4));
            if (r > 0) chk("t2_period", cyc - t_prev, 4);
            t_prev = cyc;
        end
        req = '0;
        idle(3);

        // 3: len=0 means 16 steps
        len[11:8] = 4'd0; req = 4'b0100; push(2, 16, 0);
        wait_done(40);
        req = '0;
        idle(3);

        // 4: owner abandons after 2 steps; pending req[3] served next
        len[7:4] = 4'd8; len[15:12] = 4'd2;
        req = 4'b0010; push(1, 0, 1); push(3, 2, 0);
        wait_grant(10);
        chk("t4_grant", int'(grant), 2);
        idle(1); req[3] = 1'b1;
        idle(2); req[1] = 1'b0;
        idle(1);
        chk("t4_abort", int'(abort), 1);
        chk("t4_done", int'(done), 0);
        wait_done(20);
        chk("t4_next_owner", int'(done), 8);
        req = '0;
        idle(3);

        // 5: reset mid-run restores pointer
        len[11:8] = 4'd8; len[7:4] = 4'd2; len[15:12] = 4'd1;
        req = 4'b0100;
        wait_grant(10);
        chk("t5_grant", int'(grant), 4);
        idle(3);
        clear = 1'b0;
        #1;
        chk_all_zero("midreset");
        idle(1);
        clear = 1'b1; req = 4'b1010; push(1, 2, 0); push(3, 1, 0);
        wait_grant(10);
        chk("t5_first", int'(grant), 2);
        wait_done(20);
        req = 4'b1000;
        wait_done(20);
        chk("t5_second", int'(done), 8);
        req = '0;
        idle(3);

        // 6: len change during run is ignored
        len[3:0] = 4'd3; req = 4'b0001; push(0, 3, 0);
        wait_grant(10);
        len[3:0] = 4'd9;
        wait_done(20);
        req = '0;
        idle(4);

        chk("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_counter_arbiter.md
Name: seq_counter_arbiter

Overview:
Shares one step-enabled 4-bit sequence counter between N_REQ requesters, each asking for a run of a given number of steps.
- Arbitration is round-robin.
- The block restarts the counter at code 0000 for each granted run, issues exactly the requested number of step enables, then returns the final counter code to the winner.
- It sits between the requesting control logic and the sequence-counter datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of the sequence-counter code
LEN_W, 4, width of each requested step count; 0 encodes 2^LEN_W steps

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester run request, level; held until done or abandoned
len  input  N_REQ*LEN_W  per-requester step count; slice i = len[i*LEN_W +: LEN_W]
seq_q  input  CNT_W  current code from the sequence counter
seq_clr  output  1  one-cycle synchronous restart to counter (code 0000 after the edge)
step_en  output  1  counter advances one sequence step on each edge where high
grant  output  N_REQ  one-hot owner of the counter, 0 when idle
busy  output  1  high in every state except IDLE
done  output  N_REQ  one-cycle completion pulse to the owner
result  output  CNT_W  counter code captured at completion; holds until next completion
abort  output  1  one-cycle pulse when the owner drops req mid-run

Behaviour:
- All outputs are registered.
- Reset (clear low, asynchronous):
  - State = IDLE.
  - grant, done, seq_clr, step_en, abort, busy, result, remaining = 0.
  - Round-robin pointer = N_REQ-1, so req[0] has first priority.
- State machine: IDLE -> CLR -> RUN -> DONE -> IDLE.
- IDLE:
  - If any req bit is set at an edge, pick the winner: the first set bit searching upward from pointer+1 with wrap.
  - Next cycle: grant = one-hot(winner), state = CLR, seq_clr = 1, pointer = winner.
  - Latch remaining = len[winner] (0 is loaded as 2^LEN_W).
  - len is sampled only at this edge; later changes are ignored.
- CLR:
  - Lasts exactly one cycle (seq_clr high, step_en low).
  - Next state is RUN with step_en = 1.
- RUN:
  - step_en is high for exactly remaining consecutive cycles; remaining decrements on each such edge.
  - On the edge where remaining reaches 1: step_en = 0 next cycle and state = DONE.
- DONE:
  - Lasts one cycle.
  - result <= seq_q; seq_q at this point is the code after L steps from 0000.
  - done[winner] pulses for that cycle; grant stays asserted.
  - Next cycle: grant = 0, state = IDLE.
- Re-arbitration:
  - IDLE is occupied for at least one cycle between runs.
  - Minimum run period = L+3 cycles (CLR + L RUN + DONE + IDLE).
- Grant stability: grant never changes during CLR/RUN/DONE, whatever other req bits do.
- Requests arriving while busy are held pending and arbitrated at the next IDLE.
- Abandon:
  - If req[winner] drops in CLR or RUN, the next cycle goes to IDLE with grant = 0, step_en = 0.
  - abort pulses 1 cycle, done is not pulsed, result is unchanged, and the pointer keeps the winner.
  - A drop during DONE is ignored: done still pulses.
- seq_clr and step_en are never high in the same cycle.
- Fairness: a continuously requesting requester is granted within N_REQ-1 other runs.
- Reset mid-run: immediate return to IDLE values; there is no pending done.

Test Plan:
1. Reset then req=0001, len[0]=3 -> grant=0001 one cycle later; seq_clr one cycle; step_en high 3 cycles; done[0] pulse; result=0010 (sequence 0000→0001→1111→0010); busy for 5 cycles.
2. req=1111 held, all len=1 -> grants in order 0001,0010,0100,1000,0001; each result=0001; each run 4 cycles.
3. len[2]=0 with req=0100 -> step_en high exactly 16 consecutive cycles, then done[2].
4. During req[1]'s run (len=8), req[1] drops after 2 steps -> abort pulse, grant=0 next cycle, no done, result keeps prior value; req[3] pending is granted next.
5. clear asserted low mid-RUN -> all outputs 0 immediately, pointer back to N_REQ-1; after release, req=1010 grants bit 1 first.
6. len[0] changed while running -> run length stays at the value sampled in IDLE.
